// File: rtl/vt52_pkg.sv
// Shared VT52 terminal definitions: ASCII flow-control codes and the
// software flow-control state encoding used by the receive buffer.
package vt52_pkg;

  localparam logic [7:0] ASCII_XON  = 8'h11;
  localparam logic [7:0] ASCII_XOFF = 8'h13;

  typedef enum logic [1:0] {
    FLOWING   = 2'd0,
    SEND_XOFF = 2'd1,
    STOPPED   = 2'd2,
    SEND_XON  = 2'd3
  } flow_state_t;

endpackage

// File: rtl/vt52_byte_fifo.sv
// Byte FIFO with read/write pointers and an occupancy count.
// Pushes while full are dropped; pops while empty are ignored.
module vt52_byte_fifo #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [7:0]           push_data,
  input  logic                 pop,
  output logic [7:0]           pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   fill
);

  localparam logic [ADDR_BITS:0]   FILL_FULL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   FILL_ZERO = {(ADDR_BITS+1){1'b0}};
  localparam logic [ADDR_BITS:0]   FILL_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] PTR_ZERO  = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] PTR_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [7:0]           mem_r [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_r;
  logic [ADDR_BITS-1:0] rd_ptr_r;
  logic [ADDR_BITS:0]   fill_r;
  logic                 wr_en_s;
  logic                 rd_en_s;

  // Full is judged on the registered count, so a same-cycle pop never frees room
  assign full     = (fill_r == FILL_FULL);
  assign empty    = (fill_r == FILL_ZERO);
  assign fill     = fill_r;
  assign wr_en_s  = push & ~full;
  assign rd_en_s  = pop & ~empty;
  assign pop_data = mem_r[rd_ptr_r];

  // Storage array write port
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      fill_r   <= FILL_ZERO;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({wr_en_s, rd_en_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_flow_buffer.sv
// UART receive buffer: drains the UART into a FIFO, issues XON/XOFF ahead of
// keyboard traffic on the transmit path, and reports fill and overflow.
module uart_rx_flow_buffer
  import vt52_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6,
  parameter int HI_MARK   = 48,
  parameter int LO_MARK   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flow_en,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_read,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [7:0]           kbd_data,
  input  logic                 kbd_valid,
  output logic                 kbd_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ADDR_BITS:0]   fill,
  output logic                 overflow,
  output logic                 stopped
);

  localparam logic [ADDR_BITS:0] HI_FILL = (ADDR_BITS+1)'(HI_MARK);
  localparam logic [ADDR_BITS:0] LO_FILL = (ADDR_BITS+1)'(LO_MARK);

  flow_state_t        state_r;
  flow_state_t        state_next_s;
  logic               rx_read_r;
  logic               overflow_r;
  logic               full_s;
  logic               empty_s;
  logic               pop_s;
  logic [ADDR_BITS:0] fill_s;

  vt52_byte_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_read_r),
    .push_data (rx_data),
    .pop       (pop_s),
    .pop_data  (out_data),
    .full      (full_s),
    .empty     (empty_s),
    .fill      (fill_s)
  );

  assign out_valid = ~empty_s;
  assign pop_s     = out_valid & out_ready;
  assign fill      = fill_s;
  assign rx_read   = rx_read_r;
  assign overflow  = overflow_r;
  assign stopped   = (state_r == STOPPED) || (state_r == SEND_XON);

  // Ingress pulse; the cycle of the pulse doubles as holdoff while the UART clears its flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_read_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      rx_read_r  <= rx_valid & ~rx_read_r;
      overflow_r <= overflow_r | (rx_read_r & full_s);
    end
  end

  // Flow-control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FLOWING;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Flow-control next state, driven from the registered fill level
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FLOWING: begin
        if (flow_en && (fill_s >= HI_FILL)) state_next_s = SEND_XOFF;
        else                                state_next_s = FLOWING;
      end
      SEND_XOFF: begin
        if (tx_ready) state_next_s = STOPPED;
        else          state_next_s = SEND_XOFF;
      end
      STOPPED: begin
        if ((fill_s <= LO_FILL) || !flow_en) state_next_s = SEND_XON;
        else                                 state_next_s = STOPPED;
      end
      SEND_XON: begin
        if (tx_ready) state_next_s = FLOWING;
        else          state_next_s = SEND_XON;
      end
      default: state_next_s = FLOWING;
    endcase
  end

  // Transmit arbitration: control bytes hold the path until loaded
  always_comb begin
    tx_data   = kbd_data;
    tx_valid  = kbd_valid;
    kbd_ready = kbd_valid & tx_ready;
    case (state_r)
      SEND_XOFF: begin
        tx_data   = ASCII_XOFF;
        tx_valid  = 1'b1;
        kbd_ready = 1'b0;
      end
      SEND_XON: begin
        tx_data   = ASCII_XON;
        tx_valid  = 1'b1;
        kbd_ready = 1'b0;
      end
      default: begin
        tx_data   = kbd_data;
        tx_valid  = kbd_valid;
        kbd_ready = kbd_valid & tx_ready;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_flow_buffer.sv
// Directed bench for uart_rx_flow_buffer: a table of transmit-arbitration
// vectors plus hand-written sequences for ingress, flow control and reset.
module tb_uart_rx_flow_buffer;

  logic       clk = 1'b0;
  logic       rst_n, flow_en, rx_valid, out_ready, kbd_valid, tx_ready;
  logic [7:0] rx_data, kbd_data;
  logic       rx_read, out_valid, kbd_ready, tx_valid, overflow, stopped;
  logic [7:0] out_data, tx_data;
  logic [6:0] fill;

  int n_checks = 0;
  int n_errors = 0;
  int xoff_cnt = 0;
  int xon_cnt  = 0;

  uart_rx_flow_buffer dut (
    .clk(clk), .rst_n(rst_n), .flow_en(flow_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fill(fill), .overflow(overflow), .stopped(stopped)
  );

  always #5 clk = ~clk;

  // Count control bytes loaded into the transmitter (keyboard bytes assert kbd_ready)
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready && !kbd_ready) begin
      if (tx_data == 8'h13) xoff_cnt++;
      if (tx_data == 8'h11) xon_cnt++;
    end
  end

  typedef struct {
    logic       flow_en;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       tx_ready;
    logic [7:0] exp_tx_data;
    logic       exp_tx_valid;
    logic       exp_kbd_ready;
  } arb_vec_t;

  arb_vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
  endtask

  initial begin
    int snap;
    rst_n = 1'b0; flow_en = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    out_ready = 1'b0; kbd_valid = 1'b0; kbd_data = 8'h00; tx_ready = 1'b0;

    vecs[0] = '{1'b1, 8'h61, 1'b1, 1'b1, 8'h61, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 8'h13, 1'b1, 1'b1, 8'h13, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h7a, 1'b0, 1'b0, 8'h7a, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h42, 1'b1, 1'b1, 8'h42, 1'b1, 1'b1};

    // Reset state
    do_reset();
    chk("reset_fill", fill, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_stopped", stopped, 0);
    chk("reset_rx_read", rx_read, 0);
    chk("reset_tx_valid", tx_valid, 0);

    // Keyboard pass-through table while FLOWING
    for (int i = 0; i < 5; i++) begin
      flow_en = vecs[i].flow_en; kbd_data = vecs[i].kbd_data;
      kbd_valid = vecs[i].kbd_valid; tx_ready = vecs[i].tx_ready;
      #2;
      chk($sformatf("arb%0d_tx_data", i), tx_data, vecs[i].exp_tx_data);
      chk($sformatf("arb%0d_tx_valid", i), tx_valid, vecs[i].exp_tx_valid);
      chk($sformatf("arb%0d_kbd_ready", i), kbd_ready, vecs[i].exp_kbd_ready);
      step();
    end
    kbd_valid = 1'b0; flow_en = 1'b1;

    // Single byte through the buffer
    do_reset();
    out_ready = 1'b1;
    rx_data = 8'h41; rx_valid = 1'b1;
    step();
    chk("t1_rx_read_pulse", rx_read, 1);
    chk("t1_not_yet_valid", out_valid, 0);
    rx_valid = 1'b0;
    step();
    chk("t1_rx_read_drop", rx_read, 0);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 8'h41);
    step();
    chk("t1_fill_back_0", fill, 0);
    chk("t1_out_valid_low", out_valid, 0);

    // High water mark sends one XOFF, draining to the low mark sends XON
    out_ready = 1'b0; tx_ready = 1'b1; flow_en = 1'b1;
    do_reset();
    snap = xoff_cnt;
    for (int i = 0; i < 48; i++) send_byte(8'(i));
    chk("t2_fill_48", fill, 48);
    step(); step(); step();
    chk("t2_xoff_once", xoff_cnt - snap, 1);
    chk("t2_stopped", stopped, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t2_pop%0d", i), out_data, i);
      step();
    end
    out_ready = 1'b0;
    chk("t2_fill_16", fill, 16);
    chk("t2_still_stopped", stopped, 1);
    snap = xon_cnt;
    step();
    chk("t2_xon_valid", tx_valid, 1);
    chk("t2_xon_data", tx_data, 8'h11);
    step();
    chk("t2_xon_once", xon_cnt - snap, 1);
    chk("t2_flowing", stopped, 0);

    // Overflow: 70 bytes into 64 entries
    flow_en = 1'b0;
    do_reset();
    for (int i = 0; i < 70; i++) send_byte(8'(i + 8'h20));
    chk("t3_fill_64", fill, 64);
    chk("t3_overflow", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("t3_drain%0d", i), out_data, i + 8'h20);
      step();
    end
    out_ready = 1'b0;
    chk("t3_empty", out_valid, 0);
    chk("t3_overflow_sticky", overflow, 1);

    // Keyboard byte blocked behind a stalled XOFF
    flow_en = 1'b1; tx_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 48; i++) send_byte(8'(i));
    step();
    kbd_data = 8'h61; kbd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t4_hold%0d_kbd_ready", i), kbd_ready, 0);
      chk($sformatf("t4_hold%0d_tx_data", i), tx_data, 8'h13);
      chk($sformatf("t4_hold%0d_tx_valid", i), tx_valid, 1);
      step();
    end
    tx_ready = 1'b1;
    #1;
    chk("t4_load_kbd_ready", kbd_ready, 0);
    step();
    chk("t4_kbd_tx_data", tx_data, 8'h61);
    chk("t4_kbd_ready", kbd_ready, 1);
    chk("t4_stopped", stopped, 1);
    step();
    kbd_valid = 1'b0;

    // Disabling flow control while stopped releases with XON and no further XOFF
    flow_en = 1'b0;
    step();
    chk("t5_xon_data", tx_data, 8'h11);
    chk("t5_xon_valid", tx_valid, 1);
    step();
    chk("t5_flowing", stopped, 0);
    snap = xoff_cnt;
    while (fill < 7'd64) send_byte(8'h55);
    step(); step();
    chk("t5_fill_64", fill, 64);
    chk("t5_no_xoff", xoff_cnt - snap, 0);
    chk("t5_tx_idle", tx_valid, 0);

    // Reset while an XOFF is pending
    flow_en = 1'b1; tx_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 50; i++) send_byte(8'(i));
    chk("t6_fill_50", fill, 50);
    chk("t6_xoff_pending", tx_valid, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_fill_0", fill, 0);
    chk("t6_tx_valid_0", tx_valid, 0);
    chk("t6_stopped_0", stopped, 0);
    chk("t6_out_valid_0", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
